// File: rtl/tempo_pkg.sv
// Shared constants for the tap-tempo sequencer.
//   PER_W / PER_MAX : period sample width and timeout threshold, in tp_i pulses
//   AVG_LOG2        : log2 of the averaging window
//   BPM_W           : published BPM width, results saturate at 2^BPM_W-1
//   DIV_W / DIV_NUM : divider operand width and constant numerator
//   ST_*            : sequencer state encoding
package tempo_pkg;

   localparam int unsigned PER_W    = 17;
   localparam int unsigned PER_MAX  = 62_600;
   localparam int unsigned AVG_LOG2 = 2;
   localparam int unsigned BPM_W    = 9;
   localparam int unsigned DIV_W    = 24;

   // 60e9 ns per minute / 5120 ns per time pulse
   localparam logic [DIV_W-1:0] DIV_NUM = 24'd11_718_750;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ARMED    = 2'd1;
   localparam logic [1:0] ST_READY    = 2'd2;
   localparam logic [1:0] ST_DIV_WAIT = 2'd3;

   localparam logic [DIV_W-1:0] BPM_LIMIT = DIV_W'((1 << BPM_W) - 1);

   function automatic logic [BPM_W-1:0] clamp_bpm(input logic [DIV_W-1:0] quot);
      if (quot > BPM_LIMIT) begin
         return '1;
      end
      return quot[BPM_W-1:0];
   endfunction

endpackage

// File: rtl/tempo_avg.sv
// Running average over the last 2^AVG_LOG2 tap periods.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   clear_i      : zero history and sum (highest priority)
//   load_i       : fill every history slot with sample_i
//   shift_i      : push sample_i in, drop the oldest entry
//   sample_i     : period sample
//   avg_o        : sum >> AVG_LOG2 (truncating)
module tempo_avg
   import tempo_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [PER_W-1:0] sample_i,
   output logic [PER_W-1:0] avg_o
);

   localparam int unsigned DEPTH = 1 << AVG_LOG2;
   localparam int unsigned SUM_W = PER_W + AVG_LOG2;

   logic [PER_W-1:0] hist [DEPTH];
   logic [SUM_W-1:0] sum;
   logic [SUM_W-1:0] sample_ext;
   logic [SUM_W-1:0] oldest_ext;

   assign sample_ext = SUM_W'(sample_i);
   assign oldest_ext = SUM_W'(hist[DEPTH-1]);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
         sum <= '0;
      end else if (clear_i) begin
         for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
         sum <= '0;
      end else if (load_i) begin
         for (int i = 0; i < DEPTH; i++) hist[i] <= sample_i;
         sum <= sample_ext << AVG_LOG2;
      end else if (shift_i) begin
         hist[0] <= sample_i;
         for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
         // Sum of DEPTH PER_W-bit values always fits in SUM_W bits.
         sum <= sum + sample_ext - oldest_ext;
      end
   end

   assign avg_o = PER_W'(sum >> AVG_LOG2);

endmodule

// File: rtl/tempo_sequencer.sv
// Qualifies tap periods, averages them and drives a shared divider to produce BPM.
//   clk_i, rst_i          : clock, asynchronous active-low reset
//   tp_i                  : time pulse feeding the idle timeout counter
//   per_i, per_valid_i    : measured tap period and its strobe
//   div_start_o           : one-cycle divider request
//   div_num_o, div_den_o  : divider operands (den held from start to done)
//   div_busy_i            : divider busy, blocks new starts
//   div_done_i, div_quot_i: divider completion strobe and quotient
//   bpm_o, bpm_valid_o    : clamped BPM and its update strobe
//   armed_o               : a reference tap has been seen
module tempo_sequencer
   import tempo_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             tp_i,
   input  logic [PER_W-1:0] per_i,
   input  logic             per_valid_i,
   output logic             div_start_o,
   output logic [DIV_W-1:0] div_num_o,
   output logic [PER_W-1:0] div_den_o,
   input  logic             div_busy_i,
   input  logic             div_done_i,
   input  logic [DIV_W-1:0] div_quot_i,
   output logic [BPM_W-1:0] bpm_o,
   output logic             bpm_valid_o,
   output logic             armed_o
);

   logic [1:0]       state, state_next;
   logic             pending, pending_next;
   logic [PER_W-1:0] tcnt, tcnt_next;
   logic             start, start_next;
   logic [PER_W-1:0] den, den_next;
   logic [BPM_W-1:0] bpm, bpm_next;
   logic             bpm_valid, bpm_valid_next;

   logic             avg_clear, avg_load, avg_shift;
   logic [PER_W-1:0] avg;

   logic per_taken, per_late, per_ok, tp_expire;

   // A zero period is a glitch and is treated as if no strobe arrived.
   assign per_taken = per_valid_i && (per_i != '0);
   assign per_late  = per_taken && (per_i >= PER_W'(PER_MAX));
   assign per_ok    = per_taken && !per_late;
   assign tp_expire = tp_i && (tcnt == PER_W'(PER_MAX - 1));

   tempo_avg u_avg (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (avg_clear),
      .load_i   (avg_load),
      .shift_i  (avg_shift),
      .sample_i (per_i),
      .avg_o    (avg)
   );

   always_comb begin
      state_next     = state;
      pending_next   = pending;
      tcnt_next      = tcnt;
      start_next     = 1'b0;
      den_next       = den;
      bpm_next       = bpm;
      bpm_valid_next = 1'b0;
      avg_clear      = 1'b0;
      avg_load       = 1'b0;
      avg_shift      = 1'b0;

      if (state == ST_IDLE) begin
         tcnt_next = '0;
         // First tap only establishes the reference point.
         if (per_valid_i) state_next = ST_ARMED;
      end else begin
         if (per_taken) begin
            tcnt_next = '0;
         end else if (tp_i) begin
            tcnt_next = tcnt + 1'b1;
         end

         if (per_late) begin
            // Overlong period: this tap becomes the new reference. An in-flight
            // divide finishes in ARMED, where its done is ignored.
            avg_clear    = 1'b1;
            pending_next = 1'b0;
            state_next   = ST_ARMED;
         end else if (!per_taken && tp_expire) begin
            avg_clear    = 1'b1;
            pending_next = 1'b0;
            tcnt_next    = '0;
            state_next   = ST_IDLE;
         end else begin
            if (per_ok) begin
               avg_load     = (state == ST_ARMED);
               avg_shift    = (state != ST_ARMED);
               pending_next = 1'b1;
               if (state != ST_DIV_WAIT) state_next = ST_READY;
            end
            // A sample arriving this cycle defers the start so it uses the new average.
            if (state == ST_READY && !per_ok && pending && !div_busy_i) begin
               start_next   = 1'b1;
               den_next     = avg;
               pending_next = 1'b0;
               state_next   = ST_DIV_WAIT;
            end
            if (state == ST_DIV_WAIT && div_done_i) begin
               bpm_next       = clamp_bpm(div_quot_i);
               bpm_valid_next = 1'b1;
               state_next     = ST_READY;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= ST_IDLE;
         pending   <= 1'b0;
         tcnt      <= '0;
         start     <= 1'b0;
         den       <= '0;
         bpm       <= '0;
         bpm_valid <= 1'b0;
      end else begin
         state     <= state_next;
         pending   <= pending_next;
         tcnt      <= tcnt_next;
         start     <= start_next;
         den       <= den_next;
         bpm       <= bpm_next;
         bpm_valid <= bpm_valid_next;
      end
   end

   assign div_start_o = start;
   assign div_num_o   = DIV_NUM;
   assign div_den_o   = den;
   assign bpm_o       = bpm;
   assign bpm_valid_o = bpm_valid;
   assign armed_o     = (state != ST_IDLE);

endmodule
